// File: rtl/df_wr_o_if.sv
// ---------------------------------------------------------------------------
// df_wr_o_if
//   Operand stream between the hidden-layer result producer and the
//   output-neuron operand loader (df_wr_o). This is a plain valid/ready
//   stream: a word moves on every cycle where din_valid and din_ready are
//   both high.
//
//   Signals
//     din_valid  producer -> loader   operand word is valid
//     din        producer -> loader   operand word (DATA_W bits)
//     din_ready  loader   -> producer loader can take the word this cycle
//
//   Modports
//     master  the producer side (drives din_valid/din)
//     slave   the loader side   (drives din_ready)
// ---------------------------------------------------------------------------
interface df_wr_o_if #(
  parameter int DATA_W = 16
);

  logic              din_valid;
  logic [DATA_W-1:0] din;
  logic              din_ready;

  modport master (
    output din_valid,
    output din,
    input  din_ready
  );

  modport slave (
    input  din_valid,
    input  din,
    output din_ready
  );

endinterface : df_wr_o_if

// File: rtl/df_wr_o.sv
// ---------------------------------------------------------------------------
// df_wr_o
//   Write-side loader for the output-neuron operand RAM.
//
//   A frame is DEPTH operands. The loader takes them one at a time from the
//   din_if stream and writes them to RAM addresses 0..DEPTH-1 (the write
//   strobe, address and data are registered, so each write appears one
//   cycle after its accept). Once the frame is complete it waits for rd_en,
//   then raises in_rdy for exactly DEPTH cycles so the output-neuron address
//   counter sweeps the frame once. After the sweep it counts the frame and
//   re-arms for the next one.
//
//   Parameters
//     DATA_W  width of one stored operand
//     ADDR_W  RAM address width
//     DEPTH   operands per frame, 2 <= DEPTH <= 2**ADDR_W - 1
//
//   Ports
//     clk        clock, rising edge
//     reset      asynchronous reset, active low
//     flush      synchronous abort of the current frame
//     din_if     operand stream (slave side: din_valid, din in; din_ready out)
//     rd_en      output neuron may start consuming a full frame
//     wr_en      RAM write strobe (registered)
//     wr_addr    RAM write address (registered)
//     wr_data    RAM write data (registered)
//     in_rdy     read-sweep enable to the output-neuron address counter
//     frame_cnt  completed frames, wraps 255 -> 0
// ---------------------------------------------------------------------------
module df_wr_o #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  df_wr_o_if.slave          din_if,
  input  logic              rd_en,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              in_rdy,
  output logic [7:0]        frame_cnt
);

  // FILL: collecting operands, FULL: frame stored and waiting for rd_en,
  // READ: in_rdy sweep in progress.
  typedef enum logic [1:0] {
    FILL = 2'd0,
    FULL = 2'd1,
    READ = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] wr_ptr_nxt;
  logic [ADDR_W-1:0] rd_cnt;
  logic [ADDR_W-1:0] rd_cnt_nxt;
  logic              in_rdy_nxt;
  logic [7:0]        frame_cnt_nxt;
  logic              din_ready_int;
  logic              accept;

  // The loader only takes data while filling, and never in a flush cycle,
  // so a flushed word stays with the producer and no write can ever be
  // issued while in_rdy is high.
  assign din_ready_int    = (state == FILL) && !flush;
  assign din_if.din_ready = din_ready_int;
  assign accept           = din_if.din_valid && din_ready_int;

  // Next-state and next-value logic. flush overrides every state.
  always_comb begin
    state_nxt     = state;
    wr_ptr_nxt    = wr_ptr;
    rd_cnt_nxt    = rd_cnt;
    in_rdy_nxt    = in_rdy;
    frame_cnt_nxt = frame_cnt;

    if (flush) begin
      state_nxt  = FILL;
      wr_ptr_nxt = '0;
      rd_cnt_nxt = '0;
      in_rdy_nxt = 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            if (wr_ptr == LAST_IDX) begin
              state_nxt  = FULL;
              wr_ptr_nxt = '0;
            end else begin
              wr_ptr_nxt = wr_ptr + 1'b1;
            end
          end
        end

        FULL: begin
          // rd_en is only looked at once the state register says FULL, so
          // it can never start a sweep before the last write has landed.
          if (rd_en) begin
            state_nxt  = READ;
            in_rdy_nxt = 1'b1;
            rd_cnt_nxt = '0;
          end
        end

        READ: begin
          // in_rdy stays high while rd_cnt walks 0..DEPTH-1, i.e. exactly
          // DEPTH cycles; dropping it on the last step parks the consumer.
          if (rd_cnt == LAST_IDX) begin
            state_nxt     = FILL;
            in_rdy_nxt    = 1'b0;
            rd_cnt_nxt    = '0;
            frame_cnt_nxt = frame_cnt + 8'd1;
          end else begin
            rd_cnt_nxt = rd_cnt + 1'b1;
          end
        end

        default: begin
          state_nxt  = FILL;
          wr_ptr_nxt = '0;
          rd_cnt_nxt = '0;
          in_rdy_nxt = 1'b0;
        end
      endcase
    end
  end

  // State and output registers. The RAM write port is driven straight from
  // the accept of the previous cycle; address and data simply hold their
  // last value while wr_en is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= FILL;
      wr_ptr    <= '0;
      rd_cnt    <= '0;
      in_rdy    <= 1'b0;
      frame_cnt <= 8'd0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      state     <= state_nxt;
      wr_ptr    <= wr_ptr_nxt;
      rd_cnt    <= rd_cnt_nxt;
      in_rdy    <= in_rdy_nxt;
      frame_cnt <= frame_cnt_nxt;
      wr_en     <= accept;
      if (accept) begin
        wr_addr <= wr_ptr;
        wr_data <= din_if.din;
      end
    end
  end

endmodule : df_wr_o

// File: tb/tb_df_wr_o.sv
// ---------------------------------------------------------------------------
// tb_df_wr_o
//   Self-checking bench for df_wr_o (DATA_W=16, ADDR_W=4, DEPTH=8).
//   A table of per-cycle vectors covers one complete frame (fill, FULL hold,
//   read sweep, earliest re-accept, flush); hand-written sequences cover
//   gapped input, long FULL waits, flushes, asynchronous reset and the
//   frame counter wrap.
// ---------------------------------------------------------------------------
module tb_df_wr_o;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 8;

  logic              clk;
  logic              reset;
  logic              flush;
  logic              rd_en;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              in_rdy;
  logic [7:0]        frame_cnt;

  df_wr_o_if #(.DATA_W(DATA_W)) din_if ();

  df_wr_o #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .din_if   (din_if.slave),
    .rd_en    (rd_en),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .in_rdy   (in_rdy),
    .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int overlap = 0;
  logic [7:0] exp_fc = 8'd0;

  // Any write strobe coincident with the read sweep is a RAM port conflict.
  always @(negedge clk) begin
    if (reset && wr_en && in_rdy) overlap++;
  end

  typedef struct {
    logic        fl;
    logic        v;
    logic [15:0] d;
    logic        re;
    logic        x_rdy;
    logic        x_wen;
    logic [3:0]  x_addr;
    logic [15:0] x_data;
    logic        x_in_rdy;
    logic [7:0]  x_fc;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input logic fl, input logic v, input logic [15:0] d, input logic re,
                        input logic x_rdy, input logic x_wen, input logic [3:0] x_addr,
                        input logic [15:0] x_data, input logic x_in_rdy, input logic [7:0] x_fc);
    vec_t t;
    t.fl = fl; t.v = v; t.d = d; t.re = re;
    t.x_rdy = x_rdy; t.x_wen = x_wen; t.x_addr = x_addr; t.x_data = x_data;
    t.x_in_rdy = x_in_rdy; t.x_fc = x_fc;
    vecs.push_back(t);
  endtask

  task automatic applyStimulus(input logic fl, input logic v, input logic [15:0] d, input logic re);
    flush            = fl;
    din_if.din_valid = v;
    din_if.din       = d;
    rd_en            = re;
    #1;
  endtask

  task automatic clockEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Streams one full frame base..base+DEPTH-1, valid every cycle.
  task automatic fillFrame(input logic [15:0] base);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, 1'b1, base + 16'(i), 1'b0);
      checkOutput($sformatf("fill din_ready w%0d", i), 32'(din_if.din_ready), 32'd1);
      clockEdge();
      checkOutput($sformatf("fill wr_en w%0d", i), 32'(wr_en), 32'd1);
      checkOutput($sformatf("fill wr_addr w%0d", i), 32'(wr_addr), 32'(i));
      checkOutput($sformatf("fill wr_data w%0d", i), 32'(wr_data), 32'(base + 16'(i)));
    end
  endtask

  // Starts a sweep from FULL and checks in_rdy is high for exactly DEPTH cycles.
  task automatic runRead();
    int cnt;
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b1);
    checkOutput("read full din_ready", 32'(din_if.din_ready), 32'd0);
    clockEdge();
    cnt = 0;
    while (in_rdy && cnt < 12) begin
      cnt++;
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b0);
      clockEdge();
    end
    exp_fc = exp_fc + 8'd1;
    checkOutput("read in_rdy cycles", 32'(cnt), 32'(DEPTH));
    checkOutput("read frame_cnt", 32'(frame_cnt), 32'(exp_fc));
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0);
    checkOutput("read din_ready after", 32'(din_if.din_ready), 32'd1);
  endtask

  initial begin
    reset            = 1'b0;
    flush            = 1'b0;
    rd_en            = 1'b0;
    din_if.din_valid = 1'b0;
    din_if.din       = '0;

    // Reset values, held in reset.
    #12;
    checkOutput("reset wr_en", 32'(wr_en), 32'd0);
    checkOutput("reset wr_addr", 32'(wr_addr), 32'd0);
    checkOutput("reset wr_data", 32'(wr_data), 32'd0);
    checkOutput("reset in_rdy", 32'(in_rdy), 32'd0);
    checkOutput("reset frame_cnt", 32'(frame_cnt), 32'd0);
    checkOutput("reset din_ready", 32'(din_if.din_ready), 32'd1);
    reset = 1'b1;
    clockEdge();

    // One frame cycle by cycle: 8 writes, held valid in FULL, sweep,
    // earliest re-accept, then flush of that partial frame.
    for (int i = 0; i < 8; i++)
      addVec(0, 1, 16'h0011 * 16'(i + 1), 0, 1, 1, 4'(i), 16'h0011 * 16'(i + 1), 0, 8'd0);
    addVec(0, 1, 16'h0099, 0, 0, 0, 4'd0, 16'h0, 0, 8'd0);
    addVec(0, 0, 16'h0000, 1, 0, 0, 4'd0, 16'h0, 1, 8'd0);
    for (int i = 0; i < 7; i++)
      addVec(0, 1, 16'hAAAA, 1, 0, 0, 4'd0, 16'h0, 1, 8'd0);
    addVec(0, 1, 16'hBBBB, 0, 0, 0, 4'd0, 16'h0, 0, 8'd1);
    addVec(0, 1, 16'h1234, 0, 1, 1, 4'd0, 16'h1234, 0, 8'd1);
    addVec(1, 1, 16'h5555, 0, 0, 0, 4'd0, 16'h0, 0, 8'd1);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].fl, vecs[i].v, vecs[i].d, vecs[i].re);
      checkOutput($sformatf("v%0d din_ready", i), 32'(din_if.din_ready), 32'(vecs[i].x_rdy));
      clockEdge();
      checkOutput($sformatf("v%0d wr_en", i), 32'(wr_en), 32'(vecs[i].x_wen));
      checkOutput($sformatf("v%0d in_rdy", i), 32'(in_rdy), 32'(vecs[i].x_in_rdy));
      checkOutput($sformatf("v%0d frame_cnt", i), 32'(frame_cnt), 32'(vecs[i].x_fc));
      if (vecs[i].x_wen) begin
        checkOutput($sformatf("v%0d wr_addr", i), 32'(wr_addr), 32'(vecs[i].x_addr));
        checkOutput($sformatf("v%0d wr_data", i), 32'(wr_data), 32'(vecs[i].x_data));
      end
    end
    exp_fc = 8'd1;

    // Gapped input: valid on alternate cycles, addresses must still be 0..7.
    for (int i = 0; i < 2 * DEPTH; i++) begin
      applyStimulus(1'b0, (i % 2) == 0, 16'h0100 + 16'(i / 2), 1'b0);
      clockEdge();
      checkOutput($sformatf("gap wr_en c%0d", i), 32'(wr_en), 32'((i % 2) == 0));
      if ((i % 2) == 0) begin
        checkOutput($sformatf("gap wr_addr c%0d", i), 32'(wr_addr), 32'(i / 2));
        checkOutput($sformatf("gap wr_data c%0d", i), 32'(wr_data), 32'(16'h0100 + 16'(i / 2)));
      end
    end
    // Long wait in FULL with rd_en low and valid pending.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b1, 16'hDEAD, 1'b0);
      checkOutput($sformatf("hold din_ready c%0d", i), 32'(din_if.din_ready), 32'd0);
      clockEdge();
      checkOutput($sformatf("hold in_rdy c%0d", i), 32'(in_rdy), 32'd0);
      checkOutput($sformatf("hold wr_en c%0d", i), 32'(wr_en), 32'd0);
    end
    runRead();

    // Flush after 5 accepts, then a full frame must restart at address 0.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 16'h0300 + 16'(i), 1'b0);
      clockEdge();
    end
    applyStimulus(1'b1, 1'b1, 16'h03FF, 1'b0);
    checkOutput("flush fill din_ready", 32'(din_if.din_ready), 32'd0);
    clockEdge();
    checkOutput("flush fill wr_en", 32'(wr_en), 32'd0);
    fillFrame(16'h0200);

    // Flush on the third READ cycle.
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b1);
    clockEdge();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b0);
      clockEdge();
    end
    checkOutput("flush read in_rdy before", 32'(in_rdy), 32'd1);
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0);
    clockEdge();
    checkOutput("flush read in_rdy", 32'(in_rdy), 32'd0);
    checkOutput("flush read frame_cnt", 32'(frame_cnt), 32'(exp_fc));
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0);
    checkOutput("flush read din_ready", 32'(din_if.din_ready), 32'd1);

    // Asynchronous reset in the middle of a sweep.
    fillFrame(16'h0400);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b1);
    clockEdge();
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0);
    clockEdge();
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async wr_en", 32'(wr_en), 32'd0);
    checkOutput("async wr_addr", 32'(wr_addr), 32'd0);
    checkOutput("async wr_data", 32'(wr_data), 32'd0);
    checkOutput("async in_rdy", 32'(in_rdy), 32'd0);
    checkOutput("async frame_cnt", 32'(frame_cnt), 32'd0);
    checkOutput("async din_ready", 32'(din_if.din_ready), 32'd1);
    exp_fc = 8'd0;
    #2;
    reset = 1'b1;
    clockEdge();

    // 256 frames: frame_cnt must wrap back to 0.
    for (int f = 0; f < 256; f++) begin
      fillFrame(16'(f) << 4);
      runRead();
    end
    checkOutput("fc wrap", 32'(frame_cnt), 32'd0);
    checkOutput("no write during read", 32'(overlap), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_df_wr_o
